// File: rtl/pulse_stretcher_mc_if.sv
// Bus bundle for pulse_stretcher_mc; the optional hold_len field exists only when MONO_HOLDOFF_EN is defined.
// There is no valid/ready handshake. Every input is sampled on each rising clk32 edge, and every output updates one edge later.
interface pulse_stretcher_mc_if #(
  parameter int NCH = 4,
  parameter int CW  = 8
);
  logic           en;
  logic           edge_mode;
  logic           retrig;
  logic [CW-1:0]  len;
`ifdef MONO_HOLDOFF_EN
  logic [CW-1:0]  hold_len;
`endif
  logic [NCH-1:0] din;
  logic           miss_clr;
  logic [NCH-1:0] dout;
  logic           busy;
  logic [NCH-1:0] miss;
  logic [2*NCH-1:0] dbg_state;

`ifdef MONO_HOLDOFF_EN
  modport master (output en, edge_mode, retrig, len, hold_len, din, miss_clr,
                  input dout, busy, miss, dbg_state);
  modport slave  (input en, edge_mode, retrig, len, hold_len, din, miss_clr,
                  output dout, busy, miss, dbg_state);
`else
  modport master (output en, edge_mode, retrig, len, din, miss_clr,
                  input dout, busy, miss, dbg_state);
  modport slave  (input en, edge_mode, retrig, len, din, miss_clr,
                  output dout, busy, miss, dbg_state);
`endif
endinterface

// File: rtl/pulse_stretcher_mc.sv
// Multi-channel monostable pulse stretcher; define MONO_HOLDOFF_EN to add a per-channel hold-off (HOLD) phase.
// dbg_state exposes each channel's 2-bit FSM state at bits [2*i+1:2*i].
module pulse_stretcher_mc #(
  parameter int NCH = 4,
  parameter int CW  = 8
) (
  input  logic clk32,
  input  logic rst,
  pulse_stretcher_mc_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1
`ifdef MONO_HOLDOFF_EN
    , S_HOLD = 2'd2
`endif
  } state_t;

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t         st_q   [NCH];
  state_t         st_d   [NCH];
  logic [CW-1:0]  cnt_q  [NCH];
  logic [CW-1:0]  cnt_d  [NCH];
  logic [NCH-1:0] din_d;
  logic           primed;
  logic [NCH-1:0] trig;
  logic [NCH-1:0] miss_set;
  logic [NCH-1:0] dout_d;
  logic [NCH-1:0] dout_q;
  logic [NCH-1:0] miss_q;
  logic           busy_d;
  logic           busy_q;
  logic [CW-1:0]  len_m1;
  logic [2*NCH-1:0] dbg;

  // Edge detection stays off until din_d has captured a real sample after reset.
  // This stops a level already high at reset release from looking like a rising edge.
  assign trig   = bus.edge_mode ? (bus.din & ~din_d & {NCH{primed}}) : bus.din;
  assign len_m1 = (bus.len == '0) ? '0 : (bus.len - ONE);

  always_comb begin
    dout_d   = '0;
    busy_d   = 1'b0;
    miss_set = '0;
    for (int i = 0; i < NCH; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      if (!bus.en) begin
        st_d[i]  = S_IDLE;
        cnt_d[i] = '0;
      end else begin
        case (st_q[i])
          S_IDLE: begin
            if (trig[i]) begin
              st_d[i]  = S_ACTIVE;
              cnt_d[i] = len_m1;
            end
          end
          S_ACTIVE: begin
            if (trig[i] && bus.retrig) begin
              cnt_d[i] = len_m1;
            end else begin
              miss_set[i] = trig[i];
              if (cnt_q[i] == '0) begin
                st_d[i] = S_IDLE;
`ifdef MONO_HOLDOFF_EN
                if (bus.hold_len != '0) begin
                  st_d[i]  = S_HOLD;
                  cnt_d[i] = bus.hold_len - ONE;
                end
`endif
              end else begin
                cnt_d[i] = cnt_q[i] - ONE;
              end
            end
          end
`ifdef MONO_HOLDOFF_EN
          S_HOLD: begin
            miss_set[i] = trig[i];
            if (cnt_q[i] == '0) st_d[i] = S_IDLE;
            else                cnt_d[i] = cnt_q[i] - ONE;
          end
`endif
          default: begin
            st_d[i]  = S_IDLE;
            cnt_d[i] = '0;
          end
        endcase
      end
      dout_d[i] = (st_d[i] == S_ACTIVE);
      if (st_d[i] != S_IDLE) busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk32 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        st_q[i]  <= S_IDLE;
        cnt_q[i] <= '0;
      end
      din_d  <= '0;
      primed <= 1'b0;
      dout_q <= '0;
      busy_q <= 1'b0;
      miss_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      din_d  <= bus.din;
      primed <= 1'b1;
      dout_q <= dout_d;
      busy_q <= busy_d;
      // A set arriving together with miss_clr takes priority over the clear.
      miss_q <= (miss_q & ~{NCH{bus.miss_clr}}) | miss_set;
    end
  end

  always_comb begin
    dbg = '0;
    for (int i = 0; i < NCH; i++) dbg[2*i +: 2] = st_q[i];
  end

  assign bus.dout      = dout_q;
  assign bus.busy      = busy_q;
  assign bus.miss      = miss_q;
  assign bus.dbg_state = dbg;
endmodule
